// File: rtl/pipeline_reg_pkg.sv
// Shared pipeline-register payload types and control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_reg_pkg;

    localparam int THREAD_NUM_W = 4;

    // fetch -> decode payload; thread number sits in the MSBs
    typedef struct packed {
        logic [THREAD_NUM_W-1:0] thread_num;
        logic [31:0]             pc;
        logic [31:0]             instr;
    } fetch_decode_reg;

    // decode -> lanes payload; thread number sits in the MSBs
    typedef struct packed {
        logic [THREAD_NUM_W-1:0] thread_num;
        logic [31:0]             pc;
        logic [6:0]              opcode;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [11:0]             imm;
    } decode_lanes_reg;

    // pipeline control bundle broadcast to every stage
    typedef struct packed {
        logic                    flush;
        logic                    kill_valid;
        logic [THREAD_NUM_W-1:0] kill_thread;
    } pipe_ctrl_t;

    localparam int DECODE_LANES_W = $bits(decode_lanes_reg);
    localparam int FETCH_DECODE_W = $bits(fetch_decode_reg);

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: main register plus one skid register.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !skid valid (registered), so ready never depends combinationally on out_ready.
module skid_stage
    import pipeline_reg_pkg::*;
#(
    parameter int WIDTH    = 70,
    parameter int THREAD_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    input  logic                flush,
    input  logic                kill_valid,
    input  logic [THREAD_W-1:0] kill_thread,
    output logic [1:0]          vld_cnt_nxt
);

    logic             main_vld, skid_vld;
    logic [WIDTH-1:0] main_dat, skid_dat;
    logic             main_vld_nxt, skid_vld_nxt;
    logic [WIDTH-1:0] main_dat_nxt, skid_dat_nxt;
    logic             pop, push, keep_main, keep_skid, keep_in;

    function automatic logic kill_hit(input logic [WIDTH-1:0] dat);
        return kill_valid && (dat[WIDTH-1 -: THREAD_W] == kill_thread);
    endfunction

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_dat;

    // Next state: survivors in age order (main, skid, new input) fill main first, then skid
    always_comb begin
        pop          = main_vld && out_ready;
        push         = in_valid && !skid_vld;
        keep_main    = main_vld && !pop && !kill_hit(main_dat);
        keep_skid    = skid_vld && !kill_hit(skid_dat);
        keep_in      = push && !kill_hit(in_data);
        main_vld_nxt = 1'b0;
        skid_vld_nxt = 1'b0;
        main_dat_nxt = main_dat;
        skid_dat_nxt = skid_dat;
        if (!flush) begin
            if (keep_main) begin
                main_vld_nxt = 1'b1;
                if (keep_skid) begin
                    skid_vld_nxt = 1'b1;
                end else if (keep_in) begin
                    skid_vld_nxt = 1'b1;
                    skid_dat_nxt = in_data;
                end
            end else if (keep_skid) begin
                // push is impossible while skid is full, so the input slot is empty here
                main_vld_nxt = 1'b1;
                main_dat_nxt = skid_dat;
            end else if (keep_in) begin
                main_vld_nxt = 1'b1;
                main_dat_nxt = in_data;
            end
        end
        vld_cnt_nxt = {1'b0, main_vld_nxt} + {1'b0, skid_vld_nxt};
    end

    // State registers; data cleared on reset so out_data reads zero afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            main_vld <= main_vld_nxt;
            skid_vld <= skid_vld_nxt;
            main_dat <= main_dat_nxt;
            skid_dat <= skid_dat_nxt;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: STAGES skid stages with flush, per-thread kill and occupancy.
// Latency: STAGES cycles unstalled, 1 item/cycle throughput.
// Backpressure: out_ready low stalls stages back to front; in_ready is registered per stage, gated by flush/rst.
module elastic_pipe_reg
    import pipeline_reg_pkg::*;
#(
    parameter int WIDTH    = DECODE_LANES_W,
    parameter int STAGES   = 2,
    parameter int THREAD_W = 4,
    parameter int CNT_W    = $clog2(2*STAGES+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    input  logic                flush,
    input  logic                kill_valid,
    input  logic [THREAD_W-1:0] kill_thread,
    output logic [CNT_W-1:0]    occupancy
);

    logic             vld_c [STAGES+1];
    logic             rdy_c [STAGES+1];
    logic [WIDTH-1:0] dat_c [STAGES+1];
    logic [1:0]       cnt_c [STAGES];
    logic [CNT_W-1:0] occ_nxt;

    assign vld_c[0]       = in_valid && !flush && !rst;
    assign dat_c[0]       = in_data;
    assign in_ready       = rdy_c[0] && !flush && !rst;
    assign rdy_c[STAGES]  = out_ready;
    assign out_valid      = vld_c[STAGES];
    assign out_data       = dat_c[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        skid_stage #(
            .WIDTH    (WIDTH),
            .THREAD_W (THREAD_W)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (vld_c[i]),
            .in_ready    (rdy_c[i]),
            .in_data     (dat_c[i]),
            .out_valid   (vld_c[i+1]),
            .out_ready   (rdy_c[i+1]),
            .out_data    (dat_c[i+1]),
            .flush       (flush),
            .kill_valid  (kill_valid),
            .kill_thread (kill_thread),
            .vld_cnt_nxt (cnt_c[i])
        );
    end

    // Sum next-state valid bits of all stages
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_nxt = occ_nxt + CNT_W'(cnt_c[i]);
        end
    end

    // Occupancy register tracks the valid-bit popcount after every edge
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end

endmodule
